// File: rtl/lsu_subword.sv
// Load/store unit: byte-addressed RV32 loads/stores to a word-wide data_mem, with RMW for SB/SH.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses; otherwise they are aligned down. DATA_WIDTH must be 32.
module lsu_subword #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [2:0]               funct3_i,
    input  logic [31:0]              addr_i,
    input  logic [DATA_WIDTH-1:0]    wd_i,
    output logic                     ready_o,
    output logic                     done_o,
    output logic [DATA_WIDTH-1:0]    rd_o,
    output logic                     misalign_o,
    output logic [ADDRESS_WIDTH-1:0] mem_a_o,
    output logic [DATA_WIDTH-1:0]    mem_wd_o,
    output logic                     mem_wen_o,
    input  logic [DATA_WIDTH-1:0]    mem_rd_i
);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_e;

    state_e                   state_q, state_d;
    logic                     we_q, err_q, mis_q;
    logic [2:0]               f3_q;
    logic [1:0]               lane_q;
    logic [DATA_WIDTH-1:0]    wd_q, buf_q;
    logic [ADDRESS_WIDTH-1:0] mem_a_q;

    logic                     req_illegal, req_misalign, accept;
    logic [DATA_WIDTH-1:0]    merged, load_val;
    logic [7:0]               byte_v;
    logic [15:0]              half_v;

    // Byte address bits above the word address window are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_i[31:ADDRESS_WIDTH+2];

    assign accept = (state_q == S_IDLE) && req_i;

    always_comb begin
        if (we_i) req_illegal = funct3_i[2] || (funct3_i[1:0] == 2'b11);
        else      req_illegal = (funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        req_misalign = !req_illegal &&
                       (((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                        ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)));
    end
`else
    assign req_misalign = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_i) begin
                    if (req_illegal || req_misalign)     state_d = S_DONE;
                    else if (we_i && funct3_i == 3'b010) state_d = S_WR;
                    else                                 state_d = S_RD;
                end
            end
            S_RD:    state_d = we_q ? S_WR : S_DONE;
            S_WR:    state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // mem_a only moves for accesses that will reach memory, so it holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            f3_q    <= 3'b000;
            lane_q  <= 2'b00;
            wd_q    <= '0;
            buf_q   <= '0;
            mem_a_q <= '0;
        end else begin
            if (accept) begin
                we_q   <= we_i;
                err_q  <= req_illegal;
                mis_q  <= req_misalign;
                f3_q   <= funct3_i;
                lane_q <= addr_i[1:0];
                wd_q   <= wd_i;
                if (!req_illegal && !req_misalign) mem_a_q <= addr_i[ADDRESS_WIDTH+1:2];
            end
            if (state_q == S_RD) buf_q <= mem_rd_i;
        end
    end

    always_comb begin
        merged = buf_q;
        case (f3_q[1:0])
            2'b00:   merged[{lane_q, 3'b000} +: 8]     = wd_q[7:0];
            2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wd_q[15:0];
            default: merged = wd_q;
        endcase
    end

    assign byte_v = buf_q[{lane_q, 3'b000} +: 8];
    assign half_v = buf_q[{lane_q[1], 4'b0000} +: 16];

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_val = {{16{half_v[15]}}, half_v};
            3'b100:  load_val = {24'h000000, byte_v};
            3'b101:  load_val = {16'h0000, half_v};
            default: load_val = buf_q;
        endcase
    end

    always_comb begin
        ready_o    = (state_q == S_IDLE);
        done_o     = (state_q == S_DONE);
        misalign_o = (state_q == S_DONE) && mis_q;
        rd_o       = '0;
        if (state_q == S_DONE && !we_q && !err_q && !mis_q) rd_o = load_val;
        mem_a_o    = mem_a_q;
        mem_wen_o  = (state_q == S_WR) && !rst_i;
        mem_wd_o   = (state_q == S_WR) ? merged : '0;
    end

endmodule

// File: doc/lsu_subword.md
# lsu_subword

Load/store unit between the execute stage and `data_mem`. It turns byte-addressed RISC-V loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide `data_mem` accesses. Sub-word stores use a read-modify-write sequence. The unit returns sign- or zero-extended load data through a request/done handshake. It is the only driver of the `data_mem` `a_i`, `wd_i` and `wen_i` inputs.

## Interface
- `ADDRESS_WIDTH`, default 16: word-address width presented to `data_mem`.
- `DATA_WIDTH`, default 32: memory word width. Only 32 is supported.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `req_i` in 1: access request. Sampled only when `ready_o`=1.
- `we_i` in 1: 1 = store, 0 = load.
- `funct3_i` in 3: RISC-V width/sign code.
- `addr_i` in 32: byte address.
- `wd_i` in 32: store data. Only the low bytes are used for SB/SH.
- `ready_o` out 1: unit idle and able to accept a request.
- `done_o` out 1: one-cycle pulse when an access completes.
- `rd_o` out 32: load result. Valid only while `done_o`=1, otherwise 0.
- `misalign_o` out 1: misaligned access flag. Valid with `done_o`.
- `mem_a_o` out `ADDRESS_WIDTH`: to `data_mem` `a_i`.
- `mem_wd_o` out 32: to `data_mem` `wd_i`.
- `mem_wen_o` out 1: to `data_mem` `wen_i`.
- `mem_rd_i` in 32: from `data_mem` `rd_o` (combinational read).

## Operation
- **States:** IDLE, RD, WR, DONE.
- **IDLE:**
  - `ready_o`=1.
  - On `req_i`, latch `we_i`, `funct3_i`, `addr_i` and `wd_i`.
  - Next state: SW → WR; any other legal access → RD; illegal or trapped access → DONE.
- **RD:**
  - `mem_a_o` = latched word address; `mem_wen_o`=0.
  - Register `mem_rd_i` into the word buffer.
  - Load → DONE; sub-word store → WR.
- **WR:**
  - `mem_wen_o`=1. `mem_wd_o` = merged word, or `wd_i` unchanged for SW.
  - Next state: DONE.
- **DONE:** `done_o`=1; `rd_o` and `misalign_o` driven. Next state: IDLE.
- **Word address:** `mem_a_o` = latched `addr[ADDRESS_WIDTH+1:2]`, held constant across RD and WR. Upper address bits are ignored.
- **Byte lanes:** little-endian; lane k = word[8k+7:8k], selected by `addr[1:0]`.
- **Halfword lane:** `addr[1]`.
- **Loads:**
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW returns the whole word.
- **Sub-word stores:**
  - SB replaces the selected byte lane of the buffered word with `wd_i[7:0]`.
  - SH replaces the selected halfword with `wd_i[15:0]`.
  - All other lanes keep their buffered values.
- **Illegal `funct3`:**
  - Illegal codes: loads 011/110/111; stores any code other than 000/001/010.
  - Go straight to DONE with `rd_o`=0. No memory write. `misalign_o`=0.
- **Write qualification:** `mem_wen_o` = (state==WR) && !`rst_i`, decoded from registered state only. It is never combinational from the request inputs.
- **Outside RD/WR:** `mem_wen_o`=0 and `mem_wd_o`=0. `mem_a_o` holds its last value.

## Timing
- **Reset:**
  - After the reset edge: state IDLE, `ready_o`=1.
  - `done_o`, `rd_o`, `misalign_o`, `mem_wen_o`, `mem_wd_o` and `mem_a_o` are all 0.
- **Completion latency**, counting the accept cycle as cycle 0, to `done_o`:
  - SW: 2 cycles (WR, DONE).
  - Loads: 2 cycles (RD, DONE).
  - SB/SH: 3 cycles (RD, WR, DONE).
  - Illegal or trapped access: 1 cycle.
- **Back-to-back:** a new request can be accepted no earlier than the cycle after DONE. There is no overlap.
- **Busy:** `req_i` is ignored while `ready_o`=0. Requesters hold or re-issue.
- **Memory write:** occurs in exactly one cycle (WR). Its data is ready from the word buffer captured at the end of RD.
- **Reset mid-operation:**
  - The access is abandoned.
  - `rst_i` high during WR suppresses the write, so memory is unchanged.
  - No `done_o` is produced.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:**
  - Misaligned accesses are LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0.
  - They go IDLE → DONE with `misalign_o`=1 and `rd_o`=0, and never touch memory.
- **`LSU_MISALIGN_TRAP_EN` undefined:**
  - `misalign_o` is tied 0.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]` (aligned down).
  - Normal latency applies.

## Test plan
- **Loads:** preload word 1 = 0x80FF7F01.
  - LB 0x6 → `rd_o`=0xFFFFFFFF.
  - LBU 0x7 → 0x00000080.
  - LH 0x6 → 0xFFFF80FF.
  - LHU 0x4 → 0x00007F01.
  - Each completes with `done_o` 2 cycles after accept.
- **Sub-word store:** same preload; SB 0x5 with `wd_i`=0x000000AA.
  - Expect one `mem_wen_o` cycle with `mem_a_o`=1 and `mem_wd_o`=0x80FFAA01.
  - `done_o` 3 cycles after accept.
- **SW then LW:**
  - SW 0x8 with 0xDEADBEEF: no RD cycle, `mem_wen_o` in cycle 1, `done_o` in cycle 2.
  - A following LW 0x8 returns 0xDEADBEEF.
- **Misaligned LW 0x6:**
  - With the macro: `misalign_o`=1 and `done_o` in cycle 1, `rd_o`=0, `mem_wen_o` never asserted.
  - Without the macro: returns 0x80FFAA01 in cycle 2.
- **Reset during WR of an SB:** `mem_wen_o` stays 0, word 1 is unchanged, `ready_o`=1 on the next cycle, no `done_o`.
- **Busy and illegal requests:**
  - `req_i` held high through a busy SB: exactly one access is performed.
  - A load with `funct3_i`=011 gives `done_o` in cycle 1 with `rd_o`=0 and no write.
